secuenciador_lectura_rtc: RTL and testbench

Sequencer that reads the six BCD time/date fields of the RTC register bank one at a time, drives each byte through the shared BCD-to-binary converter, range-checks the result, and latches it into binary field registers. It sits between the RTC read port and the display/alarm logic, and gives those consumers one coherent binary snapshot per `start` request. The converter is an external combinational instance: this block drives its input and samples its output in the same cycle.

---
 rtl/secuenciador_lectura_rtc.sv | 169 ++++++++++++++++
 tb/tb_secuenciador_lectura_rtc.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_lectura_rtc.sv
// Reads the six BCD time/date fields from the RTC bank, passes each through the
// external BCD-to-binary converter, range-checks it and latches a binary snapshot.
module secuenciador_lectura_rtc #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       rd_req,
  output logic [2:0] rd_addr,
  input  logic       rd_ack,
  input  logic [7:0] rd_dato,
  output logic [7:0] bcd_out,
  input  logic [6:0] bin_in,
  output logic [6:0] seg,
  output logic [6:0] min,
  output logic [6:0] hora,
  output logic [6:0] dia,
  output logic [6:0] mes,
  output logic [6:0] anio,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] err_campo
);
  // state  | meaning
  // IDLE   | waiting for start
  // REQ    | rd_req high for field r_idx, timeout down-counter running
  // CONV   | held byte on bcd_out, converter result checked and latched
  // DONE   | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CONV, S_DONE} t_estado;

  localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] C_CARGA = CW'(TIMEOUT - 1);

  t_estado       r_estado, w_estado_n;
  logic [2:0]    r_idx, w_idx_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [7:0]    r_bcd, w_bcd_n;
  logic          r_error, w_error_n;
  logic [2:0]    r_err_campo, w_err_campo_n;
  logic [6:0]    r_seg, r_min, r_hora, r_dia, r_mes, r_anio;
  logic [6:0]    w_seg_n, w_min_n, w_hora_n, w_dia_n, w_mes_n, w_anio_n;
  logic [6:0]    w_lo, w_hi;
  logic          w_valido, w_avanza;

  always_comb begin
    w_lo = 7'd0;
    w_hi = 7'd99;
    case (r_idx)
      3'd0, 3'd1: begin w_lo = 7'd0; w_hi = 7'd59; end
      3'd2:       begin w_lo = 7'd0; w_hi = 7'd23; end
      3'd3:       begin w_lo = 7'd1; w_hi = 7'd31; end
      3'd4:       begin w_lo = 7'd1; w_hi = 7'd12; end
      default:    begin w_lo = 7'd0; w_hi = 7'd99; end
    endcase
    w_valido = (bin_in != 7'h7F) && (bin_in >= w_lo) && (bin_in <= w_hi);
  end

  always_comb begin
    w_estado_n    = r_estado;
    w_idx_n       = r_idx;
    w_cnt_n       = r_cnt;
    w_bcd_n       = r_bcd;
    w_error_n     = r_error;
    w_err_campo_n = r_err_campo;
    w_seg_n       = r_seg;
    w_min_n       = r_min;
    w_hora_n      = r_hora;
    w_dia_n       = r_dia;
    w_mes_n       = r_mes;
    w_anio_n      = r_anio;
    w_avanza      = 1'b0;
    case (r_estado)
      S_IDLE: begin
        if (start) begin
          w_estado_n    = S_REQ;
          w_idx_n       = 3'd0;
          w_cnt_n       = C_CARGA;
          w_error_n     = 1'b0;
          w_err_campo_n = 3'd0;
        end
      end
      S_REQ: begin
        if (rd_ack) begin
          w_bcd_n    = rd_dato;
          w_estado_n = S_CONV;
        end else if (r_cnt == '0) begin
          w_error_n     = 1'b1;
          w_err_campo_n = r_idx;
          w_avanza      = 1'b1;
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
      S_CONV: begin
        if (w_valido) begin
          case (r_idx)
            3'd0:    w_seg_n  = bin_in;
            3'd1:    w_min_n  = bin_in;
            3'd2:    w_hora_n = bin_in;
            3'd3:    w_dia_n  = bin_in;
            3'd4:    w_mes_n  = bin_in;
            default: w_anio_n = bin_in;
          endcase
        end else begin
          w_error_n     = 1'b1;
          w_err_campo_n = r_idx;
        end
        w_avanza = 1'b1;
      end
      default: w_estado_n = S_IDLE;
    endcase
    // The NEXT step has no cycle of its own: it folds into CONV or the timeout.
    if (w_avanza) begin
      if (r_idx == 3'd5) begin
        w_estado_n = S_DONE;
      end else begin
        w_estado_n = S_REQ;
        w_idx_n    = r_idx + 3'd1;
        w_cnt_n    = C_CARGA;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado    <= S_IDLE;
      r_idx       <= 3'd0;
      r_cnt       <= '0;
      r_bcd       <= 8'h00;
      r_error     <= 1'b0;
      r_err_campo <= 3'd0;
      r_seg       <= 7'd0;
      r_min       <= 7'd0;
      r_hora      <= 7'd0;
      r_dia       <= 7'd1;
      r_mes       <= 7'd1;
      r_anio      <= 7'd0;
    end else begin
      r_estado    <= w_estado_n;
      r_idx       <= w_idx_n;
      r_cnt       <= w_cnt_n;
      r_bcd       <= w_bcd_n;
      r_error     <= w_error_n;
      r_err_campo <= w_err_campo_n;
      r_seg       <= w_seg_n;
      r_min       <= w_min_n;
      r_hora      <= w_hora_n;
      r_dia       <= w_dia_n;
      r_mes       <= w_mes_n;
      r_anio      <= w_anio_n;
    end
  end

  assign rd_req    = (r_estado == S_REQ);
  assign rd_addr   = r_idx;
  assign bcd_out   = r_bcd;
  assign busy      = (r_estado != S_IDLE);
  assign done      = (r_estado == S_DONE);
  assign error     = r_error;
  assign err_campo = r_err_campo;
  assign seg       = r_seg;
  assign min       = r_min;
  assign hora      = r_hora;
  assign dia       = r_dia;
  assign mes       = r_mes;
  assign anio      = r_anio;
endmodule

// File: tb/tb_secuenciador_lectura_rtc.sv
// Bench for secuenciador_lectura_rtc: RTC bank responder, real BCD converter and a
// per-snapshot reference model of fields, error flags and cycle counts.
module tb_secuenciador_lectura_rtc;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset, start, rd_req, rd_ack;
  logic [2:0] rd_addr, err_campo;
  logic [7:0] rd_dato, bcd_out;
  logic [6:0] bin_in, seg, min, hora, dia, mes, anio;
  logic       busy, done, error;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] bank[8];
  int         dly[8];
  bit         noise_en = 1'b0;
  int         mf[6];
  int         LO[6] = '{0, 0, 0, 1, 1, 0};
  int         HI[6] = '{59, 59, 23, 31, 12, 99};

  always #5 clk = ~clk;

  secuenciador_lectura_rtc #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_dato(rd_dato), .bcd_out(bcd_out), .bin_in(bin_in),
    .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
    .busy(busy), .done(done), .error(error), .err_campo(err_campo)
  );

  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return 7'h7F;
    return 7'(int'(b[7:4]) * 10 + int'(b[3:0]));
  endfunction

  assign bin_in = bcd2bin(bcd_out);

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_rd_req"}, rd_req, 0);
    chk({nm, "_rd_addr"}, rd_addr, 0);
    chk({nm, "_bcd_out"}, bcd_out, 0);
    chk({nm, "_seg"}, seg, 0);
    chk({nm, "_min"}, min, 0);
    chk({nm, "_hora"}, hora, 0);
    chk({nm, "_dia"}, dia, 1);
    chk({nm, "_mes"}, mes, 1);
    chk({nm, "_anio"}, anio, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_error"}, error, 0);
    chk({nm, "_err_campo"}, err_campo, 0);
  endtask

  // RTC bank: acks field a after dly[a] extra REQ cycles; dly < 0 means never.
  initial begin
    int         wcnt;
    logic       prev_req;
    logic [2:0] prev_addr;
    rd_ack = 1'b0; rd_dato = 8'h00; wcnt = 0; prev_req = 1'b0; prev_addr = 3'd0;
    forever begin
      @(negedge clk);
      if (rd_req) begin
        if (prev_req && rd_addr == prev_addr) wcnt++;
        else wcnt = 0;
        rd_ack  = (dly[rd_addr] >= 0) && (wcnt == dly[rd_addr]);
        rd_dato = rd_ack ? bank[rd_addr] : 8'($urandom);
      end else begin
        wcnt    = 0;
        rd_ack  = noise_en ? 1'($urandom) : 1'b0;
        rd_dato = 8'($urandom);
      end
      prev_req  = rd_req;
      prev_addr = rd_addr;
    end
  end

  // Runs one snapshot from a negedge; pulse_at > 1 re-pulses start mid-sequence.
  task automatic snapshot(input string nm, input int pulse_at);
    int total, done_at, first_done, busy_n, done_n, req5, req5_exp, v, limit;
    bit e_err, to;
    int e_ec;
    total = 0; e_err = 0; e_ec = 0; req5_exp = 0;
    for (int i = 0; i < 6; i++) begin
      to = (dly[i] < 0) || (dly[i] >= TIMEOUT);
      if (to) begin
        e_err = 1; e_ec = i; total += TIMEOUT;
      end else begin
        total += dly[i] + 2;
        v = int'(bcd2bin(bank[i]));
        if (v != 127 && v >= LO[i] && v <= HI[i]) mf[i] = v;
        else begin e_err = 1; e_ec = i; end
      end
      if (i == 5) req5_exp = to ? TIMEOUT : dly[i] + 1;
    end
    done_at = total + 1;
    limit = done_at + 4;
    first_done = -1; busy_n = 0; done_n = 0; req5 = 0;
    start = 1'b1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        chk({nm, "_req_first"}, rd_req, 1);
        chk({nm, "_err_clr"}, error, 0);
      end
      if (pulse_at > 1 && k == pulse_at) start = 1'b1;
      if (pulse_at > 1 && k == pulse_at + 1) start = 1'b0;
      if (done && first_done < 0) first_done = k;
      busy_n += int'(busy);
      done_n += int'(done);
      req5   += int'(rd_req && rd_addr == 3'd5);
    end
    chk({nm, "_done_at"}, first_done, done_at);
    chk({nm, "_busy_cycles"}, busy_n, done_at);
    chk({nm, "_done_pulses"}, done_n, 1);
    chk({nm, "_req5_cycles"}, req5, req5_exp);
    chk({nm, "_error"}, error, int'(e_err));
    chk({nm, "_err_campo"}, err_campo, e_ec);
    chk({nm, "_seg"}, seg, mf[0]);
    chk({nm, "_min"}, min, mf[1]);
    chk({nm, "_hora"}, hora, mf[2]);
    chk({nm, "_dia"}, dia, mf[3]);
    chk({nm, "_mes"}, mes, mf[4]);
    chk({nm, "_anio"}, anio, mf[5]);
  endtask

  task automatic set_bank(input logic [7:0] b0, b1, b2, b3, b4, b5);
    bank[0] = b0; bank[1] = b1; bank[2] = b2; bank[3] = b3; bank[4] = b4; bank[5] = b5;
    bank[6] = 8'h00; bank[7] = 8'h00;
    for (int i = 0; i < 8; i++) dly[i] = 0;
  endtask

  task automatic model_reset();
    mf = '{0, 0, 0, 1, 1, 0};
  endtask

  initial begin
    bit found;
    reset = 1'b1; start = 1'b0;
    set_bank(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    model_reset();
    #1;
    chk_reset("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    set_bank(8'h45, 8'h30, 8'h23, 8'h31, 8'h12, 8'h99);
    snapshot("zero_wait", 0);

    set_bank(8'h12, 8'h5A, 8'h08, 8'h15, 8'h06, 8'h24);
    snapshot("bad_bcd", 0);

    set_bank(8'h33, 8'h44, 8'h24, 8'h07, 8'h00, 8'h25);
    snapshot("range", 0);

    set_bank(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
    dly[3] = 3;
    snapshot("ack_dly", 0);

    set_bank(8'h59, 8'h59, 8'h00, 8'h01, 8'h01, 8'h77);
    dly[4] = TIMEOUT - 1;
    dly[5] = -1;
    snapshot("timeout", 0);

    set_bank(8'h10, 8'h20, 8'h11, 8'h28, 8'h09, 8'h50);
    snapshot("busy_start", 5);

    set_bank(8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h10);
    found = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (busy && !rd_req && rd_addr == 3'd2) found = 1'b1;
      else @(negedge clk);
    end
    chk("mid_rst_reach_conv2", int'(found), 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk_reset("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    snapshot("post_rst", 0);

    noise_en = 1'b1;
    for (int r = 0; r < 10; r++) begin
      int v;
      set_bank(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          v = int'($urandom_range(HI[i], LO[i]));
          bank[i] = {4'(v / 10), 4'(v % 10)};
        end else begin
          bank[i] = 8'($urandom);
        end
        dly[i] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      end
      snapshot($sformatf("rnd%0d", r), (r % 3 == 0) ? 4 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
